// File: rtl/pod_noc_pkg.sv
// Shared widths and FSM encoding for the pod memory reader and the pod memory side.
package pod_noc_pkg;

  localparam int D_W        = 64;
  localparam int ADDR_W     = 14;
  localparam int LEN_W      = 8;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pod_mem_reader_if.sv
// Command, pod memory read port and output stream of the pod memory reader.
interface pod_mem_reader_if #(
  parameter int D_W    = pod_noc_pkg::D_W,
  parameter int ADDR_W = pod_noc_pkg::ADDR_W,
  parameter int LEN_W  = pod_noc_pkg::LEN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [D_W-1:0]    r_data;

  logic              out_valid;
  logic              out_ready;
  logic [D_W-1:0]    out_data;
  logic              out_last;

  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, r_data, out_ready,
    output cmd_ready, r_en, r_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, r_data, out_ready,
    input  cmd_ready, r_en, r_addr, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/pod_sync_fifo.sv
// Synchronous FIFO with the head entry presented directly on dout; no push-to-pop bypass.
module pod_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pod_mem_reader.sv
// Bulk reader: issues credit-limited reads to a pod memory port and streams the
// returned words out through a FIFO with a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cmd_ready high, waiting for a burst command
// S_ISSUE | one read per cycle while ce and credits allow, len+1 total
// S_DRAIN | waiting for the last beat to be handshaked on the stream
// S_DONE  | done pulse for one cycle, then back to S_IDLE
module pod_mem_reader #(
  parameter int D_W        = pod_noc_pkg::D_W,
  parameter int ADDR_W     = pod_noc_pkg::ADDR_W,
  parameter int RD_LAT     = pod_noc_pkg::RD_LAT,
  parameter int FIFO_DEPTH = pod_noc_pkg::FIFO_DEPTH,
  parameter int LEN_W      = pod_noc_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  pod_mem_reader_if.master bus
);

  import pod_noc_pkg::*;

  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int OCC_W = CNT_W + 1;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    issue_cnt;
  logic [LEN_W:0]    beat_cnt;
  logic [RD_LAT-1:0] pipe_q;

  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;
  logic              credit_ok;
  logic              accept;
  logic              issue;
  logic              fire;
  logic              fire_last;
  logic              is_last;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [D_W-1:0]    fifo_dout;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe_q[i]);
    end
  end

  // Counting reads still in the pipe guarantees every return has a FIFO slot.
  assign occupancy = {1'b0, fifo_count} + inflight;
  assign credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));

  assign is_last   = (beat_cnt == {1'b0, len_q});
  assign fire      = ~fifo_empty & bus.out_ready;
  assign fire_last = fire & is_last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        accept = bus.cmd_valid;
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        issue = ce & credit_ok;
        if (issue && (issue_cnt == {1'b0, len_q})) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fire_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      pipe_q    <= '0;
    end else begin
      if (accept) begin
        addr_q    <= bus.cmd_addr;
        len_q     <= bus.cmd_len;
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end
      if (issue) begin
        addr_q    <= addr_q + 1'b1;
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (fire) beat_cnt <= beat_cnt + 1'b1;
      // The valid pipe tracks the memory latency, which only advances with ce.
      if (ce) begin
        pipe_q[0] <= issue;
        for (int i = 1; i < RD_LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end
  end

  assign fifo_push = ce & pipe_q[RD_LAT-1] & ~fifo_full;
  assign fifo_pop  = fire;

  pod_sync_fifo #(
    .WIDTH (D_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.r_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.cmd_ready = ~rst & (state_q == S_IDLE);
  assign bus.r_en      = ~rst & issue;
  assign bus.r_addr    = rst ? '0 : addr_q;
  assign bus.out_valid = ~rst & ~fifo_empty;
  assign bus.out_data  = rst ? '0 : fifo_dout;
  assign bus.out_last  = ~rst & ~fifo_empty & is_last;
  assign bus.busy      = ~rst & (state_q != S_IDLE);
  assign bus.done      = ~rst & (state_q == S_DONE);

endmodule

// File: tb/tb_pod_mem_reader.sv
// Directed bench for pod_mem_reader: table of bursts plus reset sequences.
module tb_pod_mem_reader;

  localparam int RDL   = 3;
  localparam int DEPTH = 8;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  len;
    int          stall;
    bit          ce_gap;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
    int          exp_beats;
    int          exp_lat;
    int          exp_span;
    int          exp_stall_iss;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  always #5 clk = ~clk;

  pod_mem_reader_if bus ();

  pod_mem_reader #(
    .RD_LAT     (RDL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  // Memory model: mem[a] = a, latency advancing only with ce.
  logic [13:0] mp [RDL];
  always @(posedge clk) begin
    if (ce) begin
      mp[0] <= bus.r_addr;
      for (int i = 1; i < RDL; i++) mp[i] <= mp[i-1];
    end
  end
  assign bus.r_data = {50'b0, mp[RDL-1]};

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_n = 0;
  int          first_valid_cyc = -1;
  int          done_cnt = 0;
  int          bad_ce = 0;
  logic [13:0] ren_q [$];
  int          ren_cyc_q [$];
  logic [63:0] beat_q [$];
  bit          last_q [$];

  always @(negedge clk) begin
    cyc_n++;
    if (!rst) begin
      if (bus.r_en) begin
        ren_q.push_back(bus.r_addr);
        ren_cyc_q.push_back(cyc_n);
        if (!ce) bad_ce++;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
      if (bus.out_valid && bus.out_ready) begin
        beat_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ren_q.delete();
    ren_cyc_q.delete();
    beat_q.delete();
    last_q.delete();
    first_valid_cyc = -1;
    done_cnt = 0;
    bad_ce = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    chk({tag, " r_en"},      64'(bus.r_en),      64'd0);
    chk({tag, " r_addr"},    64'(bus.r_addr),    64'd0);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " out_data"},  bus.out_data,       64'd0);
    chk({tag, " out_last"},  64'(bus.out_last),  64'd0);
    chk({tag, " busy"},      64'(bus.busy),      64'd0);
    chk({tag, " done"},      64'(bus.done),      64'd0);
  endtask

  task automatic run_burst(input vec_t v, input int idx);
    int          k;
    int          stall_iss;
    logic [13:0] a;
    clear_mon();
    chk($sformatf("v%0d cmd_ready before cmd", idx), 64'(bus.cmd_ready), 64'd1);
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    bus.out_ready = (v.stall == 0);
    ce = 1'b1;
    cyc();
    bus.cmd_valid = 1'b0;
    k = 0;
    stall_iss = -1;
    while (done_cnt == 0 && k < 800) begin
      if (v.ce_gap) ce = ((k % 4) == 0) || ((k % 4) == 3);
      if (k == v.stall) begin
        stall_iss = ren_q.size();
        bus.out_ready = 1'b1;
      end
      cyc();
      k++;
    end
    ce = 1'b1;
    chk($sformatf("v%0d done within budget", idx), 64'(k < 800), 64'd1);
    cyc();
    cyc();
    chk($sformatf("v%0d done pulses", idx), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d cmd_ready after", idx), 64'(bus.cmd_ready), 64'd1);
    chk($sformatf("v%0d busy after", idx), 64'(bus.busy), 64'd0);
    chk($sformatf("v%0d beat count", idx), 64'(beat_q.size()), 64'(v.exp_beats));
    chk($sformatf("v%0d issue count", idx), 64'(ren_q.size()), 64'(v.exp_beats));
    chk($sformatf("v%0d ce-low issues", idx), 64'(bad_ce), 64'd0);
    if (beat_q.size() > 0) begin
      chk($sformatf("v%0d first beat", idx), beat_q[0], v.exp_first);
      chk($sformatf("v%0d final beat", idx), beat_q[beat_q.size()-1], v.exp_last);
    end
    for (int i = 0; i < beat_q.size(); i++) begin
      a = v.addr + 14'(i);
      chk($sformatf("v%0d beat%0d data", idx, i), beat_q[i], {50'b0, a});
      chk($sformatf("v%0d beat%0d last", idx, i), 64'(last_q[i]), 64'(i == v.exp_beats - 1));
    end
    for (int i = 0; i < ren_q.size(); i++) begin
      a = v.addr + 14'(i);
      chk($sformatf("v%0d r_addr%0d", idx, i), 64'(ren_q[i]), 64'(a));
    end
    if (v.exp_lat >= 0 && ren_cyc_q.size() > 0)
      chk($sformatf("v%0d first latency", idx), 64'(first_valid_cyc - ren_cyc_q[0]), 64'(v.exp_lat));
    if (v.exp_span >= 0 && ren_cyc_q.size() > 0)
      chk($sformatf("v%0d issue span", idx), 64'(ren_cyc_q[ren_cyc_q.size()-1] - ren_cyc_q[0]), 64'(v.exp_span));
    if (v.exp_stall_iss >= 0)
      chk($sformatf("v%0d issues under stall", idx), 64'(stall_iss), 64'(v.exp_stall_iss));
  endtask

  vec_t vecs [5];
  vec_t post_rst;

  initial begin
    int k;
    vecs[0] = '{14'h0010, 8'd0,  0,  1'b0, 64'h0010, 64'h0010, 1,  4, 0,  -1};
    vecs[1] = '{14'h0100, 8'd15, 0,  1'b0, 64'h0100, 64'h010F, 16, 4, 15, -1};
    vecs[2] = '{14'h0300, 8'd31, 20, 1'b0, 64'h0300, 64'h031F, 32, 4, -1, 8};
    vecs[3] = '{14'h3FFE, 8'd3,  0,  1'b0, 64'h3FFE, 64'h0001, 4,  4, 3,  -1};
    vecs[4] = '{14'h0020, 8'd7,  0,  1'b1, 64'h0020, 64'h0027, 8, -1, -1, -1};
    post_rst = '{14'h0200, 8'd1, 0,  1'b0, 64'h0200, 64'h0201, 2,  4, 1,  -1};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    #2;
    chk("cmd_ready after reset", 64'(bus.cmd_ready), 64'd1);
    cyc();

    for (int i = 0; i < 5; i++) run_burst(vecs[i], i);

    // Reset in the middle of a burst after four issues.
    clear_mon();
    bus.out_ready = 1'b0;
    bus.cmd_addr  = 14'h0400;
    bus.cmd_len   = 8'd15;
    bus.cmd_valid = 1'b1;
    cyc();
    bus.cmd_valid = 1'b0;
    k = 0;
    while (ren_q.size() < 4 && k < 50) begin
      cyc();
      k++;
    end
    chk("mid reset issues reached", 64'(ren_q.size()), 64'd4);
    rst = 1'b1;
    #2;
    chk_all_zero("mid reset");
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("cmd_ready after mid reset", 64'(bus.cmd_ready), 64'd1);
    chk("out_valid after mid reset", 64'(bus.out_valid), 64'd0);
    clear_mon();
    repeat (8) cyc();
    chk("stale beats after reset", 64'(beat_q.size()), 64'd0);
    chk("stray issues after reset", 64'(ren_q.size()), 64'd0);
    run_burst(post_rst, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
